mc_control_fsm: RTL

Multicycle main decoder for the ARM control unit. It sequences each instruction through fetch, decode, execute, memory and writeback steps, producing the datapath select and enable signals. It also produces the unconditioned `PCS`/`RegW`/`MemW`/`NoWrite`/`FlagW` requests that the conditional-logic block gates with the condition result. It replaces the combinational single-cycle decoder when the core runs from a shared instruction/data memory.

---
 rtl/mc_control_fsm.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle main decoder for the ARM control unit.
// Sequences each instruction through fetch/decode/execute/memory/writeback
// and drives the datapath selects plus the unconditioned write requests
// that the conditional-logic block later gates.
// Optional feature: define MCFSM_CMP_EN to decode cmd=1010 (CMP) as a
// flag-only subtract; otherwise CMP is treated as an unsupported command.
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [3:0] State,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       NoWrite
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  typedef struct packed {
    logic [1:0] alu_ctl;
    logic       no_write;
    logic [1:0] flag_w;
  } alu_dec_t;

  state_t state;
  state_t state_nxt;

  logic ir_write_raw;
  logic next_pc_raw;
  logic reg_w_raw;
  logic mem_w_raw;
  logic pcs_raw;

  // ALU command decode; unsupported commands add, suppress the write and
  // leave the flags alone.
  function automatic alu_dec_t alu_decode(input logic [5:0] funct);
    alu_dec_t   d;
    logic [3:0] cmd;
    logic       s_bit;
    cmd   = funct[4:1];
    s_bit = funct[0];
    d     = '0;
    case (cmd)
      4'b0100: d = '{alu_ctl: 2'b00, no_write: 1'b0, flag_w: {s_bit, s_bit}};
      4'b0010: d = '{alu_ctl: 2'b01, no_write: 1'b0, flag_w: {s_bit, s_bit}};
      4'b0000: d = '{alu_ctl: 2'b10, no_write: 1'b0, flag_w: {s_bit, 1'b0}};
      4'b1100: d = '{alu_ctl: 2'b11, no_write: 1'b0, flag_w: {s_bit, 1'b0}};
`ifdef MCFSM_CMP_EN
      4'b1010: d = '{alu_ctl: 2'b01, no_write: 1'b1, flag_w: {s_bit, s_bit}};
`endif
      default: d = '{alu_ctl: 2'b00, no_write: 1'b1, flag_w: 2'b00};
    endcase
    return d;
  endfunction

  alu_dec_t alu_dec;
  assign alu_dec = alu_decode(Funct);

  // State register; reset aborts any instruction and parks in FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:    state_nxt = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   state_nxt = MEMADR;
          2'b00:   state_nxt = Funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_nxt = BRANCH;
          default: state_nxt = FETCH;
        endcase
      end
      MEMADR:   state_nxt = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_nxt = MEMWB;
      EXECUTER: state_nxt = ALUWB;
      EXECUTEI: state_nxt = ALUWB;
      default:  state_nxt = FETCH;
    endcase
  end

  // Moore outputs per state; write enables are masked while in reset.
  always_comb begin
    ir_write_raw = 1'b0;
    next_pc_raw  = 1'b0;
    reg_w_raw    = 1'b0;
    mem_w_raw    = 1'b0;
    pcs_raw      = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ResultSrc    = 2'b00;
    ALUControl   = 2'b00;
    FlagW        = 2'b00;
    NoWrite      = 1'b0;
    case (state)
      FETCH: begin
        ir_write_raw = 1'b1;
        next_pc_raw  = 1'b1;
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w_raw = 1'b1;
        pcs_raw   = (Rd == 4'd15);
      end
      MEMWR: begin
        AdrSrc    = 1'b1;
        mem_w_raw = 1'b1;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcB    = (state == EXECUTEI) ? 2'b01 : 2'b00;
        ALUControl = alu_dec.alu_ctl;
        NoWrite    = alu_dec.no_write;
        FlagW      = alu_dec.flag_w;
      end
      ALUWB: begin
        reg_w_raw  = 1'b1;
        pcs_raw    = (Rd == 4'd15);
        ALUControl = alu_dec.alu_ctl;
        NoWrite    = alu_dec.no_write;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcs_raw   = 1'b1;
      end
      default: ;
    endcase
  end

  assign IRWrite = ir_write_raw & reset;
  assign NextPC  = next_pc_raw  & reset;
  assign RegW    = reg_w_raw    & reset;
  assign MemW    = mem_w_raw    & reset;
  assign PCS     = pcs_raw      & reset;

  assign State  = state;
  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};

endmodule
